// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states and the
// alignment rule used to reject illegal accesses.
package mem_access_unit_pkg;

   localparam logic [1:0] MEM_NONE = 2'b00;
   localparam logic [1:0] MEM_WORD = 2'b01;
   localparam logic [1:0] MEM_BYTE = 2'b10;
   localparam logic [1:0] MEM_HALF = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RMW_RD,
      RMW_WR,
      WR,
      DONE
   } state_e;

   // Bytes are always aligned; halves need lane[0]=0, words need lane=00.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
      return ((size == MEM_WORD) && (lane != 2'b00)) ||
             ((size == MEM_HALF) && lane[0]);
   endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane steering: extracts and sign-extends loads, and merges
// sub-word store data into a fetched word for read-modify-write.
module lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [31:0] shifted;
   logic [31:0] wdata_rep;
   logic [3:0]  byte_en;

   assign shifted = rdata >> {lane, 3'b000};

   always_comb begin
      load_data = shifted;
      wdata_rep = wdata;
      byte_en   = 4'b1111;
      case (size)
         MEM_BYTE: begin
            load_data = {{24{shifted[7]}}, shifted[7:0]};
            wdata_rep = {4{wdata[7:0]}};
            byte_en   = 4'b0001 << lane;
         end
         MEM_HALF: begin
            load_data = {{16{shifted[15]}}, shifted[15:0]};
            wdata_rep = {2{wdata[15:0]}};
            byte_en   = lane[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   // Store data is replicated across lanes so the enable mask alone picks the target.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign merged[8*gi +: 8] = byte_en[gi] ? wdata_rep[8*gi +: 8] : rdata[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a word-wide memory; sub-word stores
// are done as read-modify-write, and the pipeline is stalled while busy.
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  MemRead,
   input  logic [1:0]  MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        AddrErr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   state_e      state_q, state_d;
   logic [31:0] read_data_q, read_data_d;
   logic [31:0] merge_q, merge_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  size_q, size_d;
   logic        addr_err_q, addr_err_d;

   logic        req;
   logic        illegal;
   logic [1:0]  req_size;
   logic [31:0] load_data;
   logic [31:0] merged;

   assign req      = (MemRead != MEM_NONE) || (MemWrite != MEM_NONE);
   assign req_size = (MemRead != MEM_NONE) ? MemRead : MemWrite;
   assign illegal  = ((MemRead != MEM_NONE) && (MemWrite != MEM_NONE)) ||
                     misaligned(req_size, Address[1:0]);

   lane_align u_lane_align (
      .size      (size_q),
      .lane      (addr_q[1:0]),
      .rdata     (mem_rdata),
      .wdata     (wdata_q),
      .load_data (load_data),
      .merged    (merged)
   );

   always_comb begin
      state_d     = state_q;
      read_data_d = read_data_q;
      merge_d     = merge_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      size_d      = size_q;
      addr_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               // Request fields are captured so the memory side sees stable values.
               addr_d  = Address;
               wdata_d = WriteData;
               size_d  = req_size;
               if (illegal) begin
                  addr_err_d  = 1'b1;
                  read_data_d = '0;
                  state_d     = DONE;
               end else if (MemRead != MEM_NONE) begin
                  state_d = RD;
               end else if (MemWrite == MEM_WORD) begin
                  state_d = WR;
               end else begin
                  state_d = RMW_RD;
               end
            end
         end
         RD: begin
            if (mem_ready) begin
               read_data_d = load_data;
               state_d     = DONE;
            end
         end
         RMW_RD: begin
            if (mem_ready) begin
               merge_d = merged;
               state_d = RMW_WR;
            end
         end
         RMW_WR, WR: begin
            if (mem_ready) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         read_data_q <= '0;
         merge_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         size_q      <= MEM_NONE;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         read_data_q <= read_data_d;
         merge_q     <= merge_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         size_q      <= size_d;
         addr_err_q  <= addr_err_d;
      end
   end

   assign mem_req   = state_q inside {RD, RMW_RD, RMW_WR, WR};
   assign mem_we    = (state_q == RMW_WR) || (state_q == WR);
   assign mem_addr  = (state_q == IDLE) ? Address[31:2] : addr_q[31:2];
   assign mem_wdata = (state_q == RMW_WR) ? merge_q : wdata_q;
   assign Stall     = !reset && (mem_req || ((state_q == IDLE) && req));
   assign ReadData  = read_data_q;
   assign AddrErr   = addr_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of load/store vectors against a
// small behavioural memory, plus sequences for wait states, DONE and reset.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  MemRead, MemWrite;
   logic [31:0] Address, WriteData;
   logic [31:0] ReadData;
   logic        Stall, AddrErr;
   logic        mem_req, mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_ready;

   int checks = 0;
   int errors = 0;

   mem_access_unit dut (
      .clk       (clk),
      .reset     (reset),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .Address   (Address),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .Stall     (Stall),
      .AddrErr   (AddrErr),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   always #5 clk = ~clk;

   // Behavioural memory: ready after ready_delay waiting cycles of mem_req.
   logic [31:0] mem [0:255];
   logic        preload;
   int          ready_delay;
   int          wait_cnt;
   int          req_cnt;
   int          wr_cnt;

   assign mem_rdata = mem[mem_addr[7:0]];
   assign mem_ready = mem_req && (wait_cnt >= ready_delay);

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[8'h40] <= 32'h8899AABB;
         mem[8'h41] <= 32'h12345678;
         req_cnt    <= 0;
         wr_cnt     <= 0;
         wait_cnt   <= 0;
      end else begin
         if (mem_req && mem_we && mem_ready) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
         end
         if (mem_req) req_cnt <= req_cnt + 1;
         wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_op(input logic [1:0] rd, input logic [1:0] wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int stall_cyc, output int err_cnt);
      @(negedge clk);
      MemRead   = rd;
      MemWrite  = wr;
      Address   = addr;
      WriteData = wd;
      stall_cyc = 0;
      err_cnt   = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (AddrErr) err_cnt++;
         if (!Stall) break;
         stall_cyc++;
         @(negedge clk);
      end
      MemRead  = 2'b00;
      MemWrite = 2'b00;
      @(negedge clk);
      #1;
      if (AddrErr) err_cnt++;
   endtask

   typedef struct {
      logic [1:0]  rd;
      logic [1:0]  wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rdata;
      int          exp_stall;
      int          exp_err;
      int          exp_req;
      int          exp_wr;
      logic [31:0] exp_mem;
   } vec_t;

   vec_t vecs[16];

   initial begin
      int stall_cyc, err_cnt, req0, wr0, found;
      logic [31:0] prev_rd;

      vecs[0]  = '{2'b10, 2'b00, 32'h103, 32'h0,        32'hFFFFFF88, 2, 0, 1, 0, 32'h8899AABB};
      vecs[1]  = '{2'b11, 2'b00, 32'h102, 32'h0,        32'hFFFF8899, 2, 0, 1, 0, 32'h8899AABB};
      vecs[2]  = '{2'b01, 2'b00, 32'h100, 32'h0,        32'h8899AABB, 2, 0, 1, 0, 32'h8899AABB};
      vecs[3]  = '{2'b10, 2'b00, 32'h100, 32'h0,        32'hFFFFFFBB, 2, 0, 1, 0, 32'h8899AABB};
      vecs[4]  = '{2'b10, 2'b00, 32'h104, 32'h0,        32'h00000078, 2, 0, 1, 0, 32'h8899AABB};
      vecs[5]  = '{2'b11, 2'b00, 32'h106, 32'h0,        32'h00001234, 2, 0, 1, 0, 32'h8899AABB};
      vecs[6]  = '{2'b00, 2'b10, 32'h101, 32'h000000CC, 32'h00001234, 3, 0, 2, 1, 32'h8899CCBB};
      vecs[7]  = '{2'b00, 2'b11, 32'h101, 32'h00000000, 32'h00000000, 1, 1, 0, 0, 32'h8899CCBB};
      vecs[8]  = '{2'b01, 2'b00, 32'h100, 32'h0,        32'h8899CCBB, 2, 0, 1, 0, 32'h8899CCBB};
      vecs[9]  = '{2'b00, 2'b11, 32'h102, 32'hFFFF1357, 32'h8899CCBB, 3, 0, 2, 1, 32'h1357CCBB};
      vecs[10] = '{2'b00, 2'b01, 32'h100, 32'hDEADBEEF, 32'h8899CCBB, 2, 0, 1, 1, 32'hDEADBEEF};
      vecs[11] = '{2'b01, 2'b00, 32'h102, 32'h0,        32'h00000000, 1, 1, 0, 0, 32'hDEADBEEF};
      vecs[12] = '{2'b01, 2'b01, 32'h100, 32'h0,        32'h00000000, 1, 1, 0, 0, 32'hDEADBEEF};
      vecs[13] = '{2'b10, 2'b00, 32'h103, 32'h0,        32'hFFFFFFDE, 2, 0, 1, 0, 32'hDEADBEEF};
      vecs[14] = '{2'b11, 2'b00, 32'h100, 32'h0,        32'hFFFFBEEF, 2, 0, 1, 0, 32'hDEADBEEF};
      vecs[15] = '{2'b00, 2'b10, 32'h103, 32'h00000011, 32'hFFFFBEEF, 3, 0, 2, 1, 32'h11ADBEEF};

      reset       = 1'b1;
      preload     = 1'b1;
      ready_delay = 0;
      MemRead     = 2'b00;
      MemWrite    = 2'b00;
      Address     = 32'h0;
      WriteData   = 32'h0;

      // Reset state, with a request present to show Stall is forced low.
      repeat (2) @(negedge clk);
      preload = 1'b0;
      MemRead = 2'b01;
      Address = 32'h100;
      #1;
      chk("reset_stall_forced", {31'b0, Stall}, 32'h0);
      MemRead = 2'b00;
      @(negedge clk);
      #1;
      chk("reset_readdata", ReadData, 32'h0);
      chk("reset_mem_req", {31'b0, mem_req}, 32'h0);
      chk("reset_mem_we", {31'b0, mem_we}, 32'h0);
      chk("reset_addrerr", {31'b0, AddrErr}, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      #1;
      chk("idle_stall", {31'b0, Stall}, 32'h0);

      for (int v = 0; v < 16; v++) begin
         req0 = req_cnt;
         wr0  = wr_cnt;
         do_op(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wd, stall_cyc, err_cnt);
         $display("vec %0d: rd=%b wr=%b addr=0x%03h wd=0x%08h -> ReadData=0x%08h stall=%0d err=%0d req=%0d wr=%0d mem=0x%08h",
                  v, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wd, ReadData, stall_cyc,
                  err_cnt, req_cnt - req0, wr_cnt - wr0, mem[8'h40]);
         chk($sformatf("vec%0d_readdata", v), ReadData, vecs[v].exp_rdata);
         chk($sformatf("vec%0d_stall", v), stall_cyc, vecs[v].exp_stall);
         chk($sformatf("vec%0d_addrerr", v), err_cnt, vecs[v].exp_err);
         chk($sformatf("vec%0d_req_cycles", v), req_cnt - req0, vecs[v].exp_req);
         chk($sformatf("vec%0d_writes", v), wr_cnt - wr0, vecs[v].exp_wr);
         chk($sformatf("vec%0d_memword", v), mem[8'h40], vecs[v].exp_mem);
      end

      // Slow memory on lw: 3 wait cycles, address and ReadData must hold.
      ready_delay = 3;
      prev_rd = ReadData;
      @(negedge clk);
      MemRead = 2'b01;
      Address = 32'h104;
      stall_cyc = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (!Stall) break;
         stall_cyc++;
         if (mem_req && !mem_ready) begin
            chk("slow_mem_addr", {2'b0, mem_addr}, 32'h41);
            chk("slow_readdata_hold", ReadData, prev_rd);
         end
         @(negedge clk);
      end
      MemRead = 2'b00;
      $display("slow lw 0x104: stall=%0d ReadData=0x%08h", stall_cyc, ReadData);
      chk("slow_stall", stall_cyc, 5);
      chk("slow_readdata", ReadData, 32'h12345678);
      @(negedge clk);

      // Inputs held through DONE must not start a new access there.
      ready_delay = 0;
      @(negedge clk);
      MemRead = 2'b01;
      Address = 32'h100;
      repeat (2) @(negedge clk);
      #1;
      chk("done_stall", {31'b0, Stall}, 32'h0);
      @(negedge clk);
      #1;
      chk("after_done_no_req", {31'b0, mem_req}, 32'h0);
      MemRead = 2'b00;
      $display("held lw through DONE: ReadData=0x%08h", ReadData);
      @(negedge clk);

      // Reset during RMW_WR abandons the write.
      ready_delay = 3;
      wr0 = wr_cnt;
      @(negedge clk);
      MemWrite  = 2'b10;
      Address   = 32'h100;
      WriteData = 32'h00000055;
      found = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (mem_req && mem_we) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      chk("rmw_wr_reached", found, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_rmw_mem_req", {31'b0, mem_req}, 32'h0);
      chk("rst_rmw_stall", {31'b0, Stall}, 32'h0);
      chk("rst_rmw_readdata", ReadData, 32'h0);
      @(negedge clk);
      reset    = 1'b0;
      MemWrite = 2'b00;
      #1;
      chk("rst_rmw_idle_req", {31'b0, mem_req}, 32'h0);
      chk("rst_rmw_idle_stall", {31'b0, Stall}, 32'h0);
      @(negedge clk);
      #1;
      chk("rst_rmw_no_write", wr_cnt - wr0, 0);
      chk("rst_rmw_memword", mem[8'h40], 32'h11ADBEEF);
      $display("reset in RMW_WR: mem_req=%b ReadData=0x%08h mem=0x%08h", mem_req, ReadData, mem[8'h40]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port MemRead, input, 2 bits: load size code from the decoder (00 none, 01 word, 10 byte, 11 half).
REQ-004 SHALL have port MemWrite, input, 2 bits: store size code, same encoding as MemRead.
REQ-005 SHALL have port Address, input, 32 bits: byte address from the ALU.
REQ-006 SHALL have port WriteData, input, 32 bits: store data; low byte or low half is used for sb/sh.
REQ-007 SHALL have port ReadData, output, 32 bits: registered load result, sign-extended for lb/lh.
REQ-008 SHALL have port Stall, output, 1 bit: pipeline hold request.
REQ-009 SHALL have port AddrErr, output, 1 bit: one-cycle pulse flagging a misaligned or illegal access.
REQ-010 SHALL have port mem_req, output, 1 bit: memory request.
REQ-011 SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-012 SHALL have port mem_addr, output, 30 bits: word address, equal to Address[31:2].
REQ-013 SHALL have port mem_wdata, output, 32 bits: full-word write data.
REQ-014 SHALL have port mem_rdata, input, 32 bits: word read data.
REQ-015 SHALL have port mem_ready, input, 1 bit: memory completion.

Function
REQ-016 SHALL implement the FSM states IDLE, RD, RMW_RD, RMW_WR, WR and DONE.
REQ-017 In IDLE, a request (MemRead≠00 or MemWrite≠00) SHALL be accepted: word/byte/half load -> RD; word store -> WR; byte/half store -> RMW_RD.
REQ-018 Byte lane = Address[1:0], little-endian; a half occupies lanes {Address[1],0} and {Address[1],1}.
REQ-019 Word access with Address[1:0]≠00, half access with Address[0]=1, or MemRead≠00 and MemWrite≠00 together SHALL NOT issue mem_req, SHALL pulse AddrErr for 1 cycle, set ReadData=0, and go to DONE.
REQ-020 mem_req SHALL be high in RD, RMW_RD, RMW_WR and WR, with mem_addr, mem_we and mem_wdata held stable until mem_ready is sampled high; mem_we is high only in WR and RMW_WR.
REQ-021 RD with mem_ready: the extracted and extended value SHALL be registered into ReadData, then go to DONE.
REQ-022 RMW_RD with mem_ready: the fetched word SHALL be captured, the store byte/half merged into the addressed lanes, then go to RMW_WR.
REQ-023 RMW_WR or WR with mem_ready SHALL go to DONE.
REQ-024 Stall SHALL be 1 in IDLE when a request is present, 1 in RD/RMW_RD/RMW_WR/WR, and 0 in DONE.
REQ-025 DONE -> IDLE unconditionally; inputs seen in DONE SHALL NOT be re-accepted.
REQ-026 ReadData SHALL hold its value until the next completed load; stores SHALL NOT modify it.
REQ-027 With mem_ready tied high: loads and word stores SHALL stall for 2 cycles; byte/half stores SHALL stall for 3 cycles.

Reset
REQ-028 On reset: state=IDLE, ReadData=0, merge register=0, mem_req=0, mem_we=0, AddrErr=0, Stall=0 (forced while reset is high).
REQ-029 Reset mid-transaction SHALL abandon the access at that edge with no further mem_req; the memory side tolerates an abandoned request.

Structure
REQ-030 A shared package SHALL hold the size-code constants (MEM_NONE, MEM_WORD, MEM_BYTE, MEM_HALF) and the FSM state enum.
REQ-031 A sub-module lane_align SHALL be combinational: load extract plus sign-extend, and store lane merge.

Verification (memory word 0x100 preloaded with 0x8899AABB)
REQ-032 lb at 0x103 -> ReadData=0xFFFFFF88, Stall high for 2 cycles.
REQ-033 lh at 0x102 -> 0xFFFF8899; lw at 0x100 -> 0x8899AABB.
REQ-034 sb at 0x101 with WriteData=0x000000CC -> memory word becomes 0x8899CCBB, exactly one read then one write, Stall high for 3 cycles.
REQ-035 sh at 0x101 -> AddrErr pulses once, no mem_req, memory unchanged.
REQ-036 mem_ready delayed 3 cycles on lw -> Stall held throughout, mem_addr stable, ReadData updated only after mem_ready.
REQ-037 reset asserted in RMW_WR -> mem_req=0 next cycle, state IDLE, ReadData=0.
